mem_copy_engine: RTL and testbench
==================================

# mem_copy_engine

Bus initiator that drives the data memory port (DataAddress, ReadMem, WriteMem, write data, read data) to copy a block of bytes from a source address to a destination address without CPU involvement. It sits beside the core and is muxed onto the data memory's request port while Busy is high. It is the requesting end of the same single-cycle memory interface: combinational read data and a write on the clock rise.

## Interface
- ADDR_W, 8, address width; also the width of Len
- DATA_W, 8, data width
- clk  input  1  system clock; all state updates on the rising edge
- rst_n  input  1  reset, asynchronous, active-low
- Start  input  1  request a copy; sampled only in IDLE
- SrcAddr  input  ADDR_W  first source byte address; sampled with Start
- DstAddr  input  ADDR_W  first destination byte address; sampled with Start
- Len  input  ADDR_W  byte count (0..255); sampled with Start
- Busy  output  1  high in READ and WRITE
- Done  output  1  one-cycle pulse when a copy completes
- DataAddress  output  ADDR_W  memory address
- ReadMem  output  1  memory read strobe
- WriteMem  output  1  memory write strobe
- WrData  output  DATA_W  data to the memory's DataIn
- RdData  input  DATA_W  the memory's DataOut, combinational from DataAddress
- Checksum  output  DATA_W  present only with MEM_COPY_CHECKSUM_EN

## Operation
- States:
  - IDLE: waits for Start.
  - READ: ReadMem=1, DataAddress=src_ptr. At the edge, RdData is captured into buf.
  - WRITE: WriteMem=1, DataAddress=dst_ptr, WrData=buf. At the edge, both pointers increment and the remaining count decrements.
  - DONE: Done=1 for one cycle, then IDLE.
- Transitions:
  - IDLE with Start=1 and Len≠0 goes to READ and latches the pointers and count.
  - IDLE with Start=1 and Len=0 goes directly to DONE. No memory access occurs.
  - READ always goes to WRITE.
  - WRITE goes to READ if the remaining count after the decrement is ≠0, otherwise to DONE.
- Start is ignored in READ, WRITE and DONE. It is not queued. A copy can be accepted in the cycle after DONE at the earliest.
- Pointer arithmetic is modulo 2^ADDR_W, so 0xFF+1 wraps to 0x00. Ranges that wrap are legal.
- Overlapping ranges: the copy is strictly forward, byte by byte. If Dst>Src inside the range, the source bytes replicate. This is defined behaviour, not an error.
- ReadMem and WriteMem are never high together. Both are 0 in IDLE and DONE.
- DataAddress and WrData are 0 in IDLE and DONE.

## Timing
- Reset values: state IDLE; Busy=0, Done=0, ReadMem=0, WriteMem=0, DataAddress=0, WrData=0, Checksum=0; internal pointers, count and buf all 0.
- Reset is asynchronous. Asserting rst_n low mid-copy forces WriteMem low immediately, and no further writes occur. Destination bytes already written stay written.
- Outputs are decoded from the registered state, pointers and buf. There is no combinational path from Start to the memory strobes.
- Latency for a copy of N≥1 bytes, Start accepted at edge 0:
  - Busy is high from edge 0 to edge 2N, which is 2N cycles.
  - Done is high for the cycle after edge 2N.
  - IDLE is reached at edge 2N+1.
- Latency for N=0: Done is high in the cycle after edge 0. Busy stays 0.
- The write of byte i lands at the rising edge ending WRITE cycle i. A read in the same copy cycle therefore sees the updated memory.

## Configuration
- MEM_COPY_CHECKSUM_EN defined:
  - The Checksum port exists.
  - Checksum is cleared to 0 when Start is accepted.
  - Each captured RdData is XORed into Checksum at the READ edge.
  - Checksum holds its value from DONE until the next accepted Start, and is valid when Done=1.
- MEM_COPY_CHECKSUM_EN undefined: no Checksum port and no accumulator register. All other behaviour is identical.

## Structure
- Shared package pebble_mem_pkg holds:
  - ADDR_W and DATA_W defaults
  - the state enum copy_state_t (IDLE, READ, WRITE, DONE)
- No sub-module is needed. This is a single FSM with a datapath (two pointers, a down-counter, buf and an optional accumulator).
- Bench: instantiate with data_mem as the responder.

## Test plan
- Preload mem[0x10..0x13]=0xA1,0xB2,0xC3,0xD4, then Start with Src=0x10, Dst=0x40, Len=4 -> mem[0x40..0x43] matches the source. Busy is high for 8 cycles. Done pulses once at cycle 9. Checksum=0xA1^0xB2^0xC3^0xD4=0x04.
- Len=0 with Src=0x20, Dst=0x30 -> ReadMem and WriteMem never assert. Done pulses in the cycle after Start. Busy stays 0. Memory is unchanged.
- Wrap: Src=0xFE, Dst=0x01, Len=3, mem[0xFE]=0x11, mem[0xFF]=0x22, mem[0x00]=0x33 -> mem[0x01..0x03]=0x11,0x22,0x33. The third read uses DataAddress=0x00.
- Overlap: mem[0x50]=0x7E, Src=0x50, Dst=0x51, Len=3 -> mem[0x51..0x53] are all 0x7E.
- Start held high through a Len=2 copy with Src=0x60, Dst=0x70 -> exactly one copy occurs. A second copy is accepted only at the edge after the Done cycle.
- rst_n pulsed low during the third WRITE cycle of a Len=5 copy with Dst=0x80 -> WriteMem=0 and Busy=0 immediately. mem[0x80..0x81] are written and mem[0x82..0x84] are unchanged. Done never pulses. The FSM is in IDLE after release.

Source files
------------

// File: rtl/pebble_mem_pkg.sv
// Shared definitions for the pebble data-memory initiators.
// Holds the default bus widths and the copy engine's state encoding.
package pebble_mem_pkg;

  localparam int ADDR_W_DEFAULT = 8;
  localparam int DATA_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } copy_state_t;

endpackage

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: DMA-style initiator that copies Len bytes from SrcAddr to
// DstAddr over the single-cycle data memory port, one READ and one WRITE
// cycle per byte, strictly forward. Optional macro MEM_COPY_CHECKSUM_EN adds
// a Checksum port holding the XOR of every byte read during the copy.
module mem_copy_engine
  import pebble_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Start,
  input  logic [ADDR_W-1:0] SrcAddr,
  input  logic [ADDR_W-1:0] DstAddr,
  input  logic [ADDR_W-1:0] Len,
  output logic              Busy,
  output logic              Done,
  output logic [ADDR_W-1:0] DataAddress,
  output logic              ReadMem,
  output logic              WriteMem,
  output logic [DATA_W-1:0] WrData,
  input  logic [DATA_W-1:0] RdData
`ifdef MEM_COPY_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] Checksum
`endif
);

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  copy_state_t       state, next_state;
  logic [ADDR_W-1:0] src_ptr, dst_ptr, count;
  logic [DATA_W-1:0] data_buf;
  logic              accept;

  // A request is taken only from IDLE; a zero-length request still counts as
  // accepted so it produces its Done pulse and clears the checksum.
  assign accept = (state == IDLE) && Start;

  // State register; reset lands in IDLE so strobes drop immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state and output decode purely from registered state and datapath.
  always_comb begin
    next_state  = state;
    Busy        = 1'b0;
    Done        = 1'b0;
    ReadMem     = 1'b0;
    WriteMem    = 1'b0;
    DataAddress = '0;
    WrData      = '0;
    unique case (state)
      IDLE: begin
        if (Start) next_state = (Len != '0) ? READ : DONE;
      end
      READ: begin
        Busy        = 1'b1;
        ReadMem     = 1'b1;
        DataAddress = src_ptr;
        next_state  = WRITE;
      end
      WRITE: begin
        Busy        = 1'b1;
        WriteMem    = 1'b1;
        DataAddress = dst_ptr;
        WrData      = data_buf;
        next_state  = (count != ONE) ? READ : DONE;
      end
      DONE: begin
        Done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Pointers, remaining count and the byte in flight between READ and WRITE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_ptr  <= '0;
      dst_ptr  <= '0;
      count    <= '0;
      data_buf <= '0;
    end else begin
      if (accept) begin
        src_ptr <= SrcAddr;
        dst_ptr <= DstAddr;
        count   <= Len;
      end
      if (state == READ) data_buf <= RdData;
      if (state == WRITE) begin
        src_ptr <= src_ptr + ONE;
        dst_ptr <= dst_ptr + ONE;
        count   <= count - ONE;
      end
    end
  end

`ifdef MEM_COPY_CHECKSUM_EN
  // Running XOR of every byte read; cleared on accept, held after the copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              Checksum <= '0;
    else if (accept)         Checksum <= '0;
    else if (state == READ)  Checksum <= Checksum ^ RdData;
  end
`endif

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine. A behavioural byte array acts as
// the data memory responder; a separate reference array is updated by a
// plain forward-copy model and compared against it after every copy.
module tb_mem_copy_engine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       Start = 1'b0;
  logic [7:0] SrcAddr = '0, DstAddr = '0, Len = '0;
  logic       Busy, Done, ReadMem, WriteMem;
  logic [7:0] DataAddress, WrData, RdData;
`ifdef MEM_COPY_CHECKSUM_EN
  logic [7:0] Checksum;
`endif

  logic [7:0] data_mem [256];
  logic [7:0] ref_mem  [256];
  int checks = 0;
  int failures = 0;

  mem_copy_engine dut (
    .clk(clk), .rst_n(rst_n), .Start(Start), .SrcAddr(SrcAddr),
    .DstAddr(DstAddr), .Len(Len), .Busy(Busy), .Done(Done),
    .DataAddress(DataAddress), .ReadMem(ReadMem), .WriteMem(WriteMem),
    .WrData(WrData), .RdData(RdData)
`ifdef MEM_COPY_CHECKSUM_EN
    , .Checksum(Checksum)
`endif
  );

  always #5 clk = ~clk;

  // Single-cycle memory: combinational read, write on the rising edge.
  assign RdData = data_mem[DataAddress];
  always @(posedge clk) if (WriteMem) data_mem[DataAddress] <= WrData;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Forward byte-by-byte copy with 8-bit wrap; checksum is XOR of bytes read.
  task automatic modelCopy(input logic [7:0] src, input logic [7:0] dst,
                           input int n, output logic [7:0] cks);
    logic [7:0] s, d, b;
    cks = '0;
    for (int i = 0; i < n; i++) begin
      s = src + 8'(i);
      d = dst + 8'(i);
      b = ref_mem[s];
      cks ^= b;
      ref_mem[d] = b;
    end
  endtask

  task automatic checkMemory(input string tag);
    int diffs = 0;
    for (int a = 0; a < 256; a++) if (data_mem[a] !== ref_mem[a]) diffs++;
    checkOutput({tag, "_mem"}, diffs, 0);
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] v);
    data_mem[a] = v;
    ref_mem[a]  = v;
  endtask

  // Issue one copy and watch it cycle by cycle; cycle c is the cycle after
  // edge c-1, where edge 0 is the accepting edge.
  task automatic applyStimulus(input string tag, input logic [7:0] src,
                               input logic [7:0] dst, input int n, input bit hold);
    logic [7:0] exp_cks, got_cks;
    int busy_cnt = 0, done_cnt = 0, done_cyc = -1, both_cnt = 0, addr_err = 0;
    int strobe_cnt = 0, w;
    bit seen;
    @(negedge clk);
    Start = 1'b1; SrcAddr = src; DstAddr = dst; Len = 8'(n);
    modelCopy(src, dst, n, exp_cks);
    got_cks = '0;
    @(posedge clk);
    #1;
    if (!hold) Start = 1'b0;
    w = 2 * n + 2;
    for (int c = 1; c <= w; c++) begin
      @(negedge clk);
      busy_cnt += int'(Busy);
      strobe_cnt += int'(ReadMem) + int'(WriteMem);
      if (ReadMem && WriteMem) both_cnt++;
      if (c <= 2 * n && (c % 2) == 1 && (!ReadMem || DataAddress != src + 8'((c - 1) / 2))) addr_err++;
      if (c <= 2 * n && (c % 2) == 0 && (!WriteMem || DataAddress != dst + 8'((c - 2) / 2))) addr_err++;
      if (Done) begin
        done_cnt++;
        done_cyc = c;
`ifdef MEM_COPY_CHECKSUM_EN
        got_cks = Checksum;
`endif
      end
    end
    checkOutput({tag, "_busy_cycles"}, busy_cnt, 2 * n);
    checkOutput({tag, "_done_count"}, done_cnt, 1);
    checkOutput({tag, "_done_cycle"}, done_cyc, 2 * n + 1);
    checkOutput({tag, "_strobe_overlap"}, both_cnt, 0);
    checkOutput({tag, "_addr_seq"}, addr_err, 0);
    checkOutput({tag, "_strobe_total"}, strobe_cnt, 2 * n);
`ifdef MEM_COPY_CHECKSUM_EN
    checkOutput({tag, "_checksum"}, got_cks, exp_cks);
`endif
    checkMemory(tag);
    if (hold) begin
      // Start still high: the second copy is taken at the edge after Done.
      @(negedge clk);
      checkOutput({tag, "_second_accept"}, Busy, 1);
      Start = 1'b0;
      modelCopy(src, dst, n, exp_cks);
      seen = 1'b0;
      for (int c = 0; c < 4 * n + 8 && !seen; c++) begin
        @(negedge clk);
        if (Done) seen = 1'b1;
      end
      checkOutput({tag, "_second_done"}, seen, 1);
      checkMemory({tag, "_second"});
    end
  endtask

  initial begin
    logic [7:0] dummy;
    bit done_seen;
    for (int a = 0; a < 256; a++) poke(8'(a), 8'($urandom));

    // Reset state while rst_n is held low.
    #12;
    checkOutput("rst_busy", Busy, 0);
    checkOutput("rst_done", Done, 0);
    checkOutput("rst_strobes", {ReadMem, WriteMem}, 0);
    checkOutput("rst_addr", DataAddress, 0);
    checkOutput("rst_wrdata", WrData, 0);
`ifdef MEM_COPY_CHECKSUM_EN
    checkOutput("rst_checksum", Checksum, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    poke(8'h10, 8'hA1); poke(8'h11, 8'hB2); poke(8'h12, 8'hC3); poke(8'h13, 8'hD4);
    applyStimulus("basic", 8'h10, 8'h40, 4, 1'b0);
    applyStimulus("len0", 8'h20, 8'h30, 0, 1'b0);
    poke(8'hFE, 8'h11); poke(8'hFF, 8'h22); poke(8'h00, 8'h33);
    applyStimulus("wrap", 8'hFE, 8'h01, 3, 1'b0);
    poke(8'h50, 8'h7E);
    applyStimulus("overlap", 8'h50, 8'h51, 3, 1'b0);
    applyStimulus("hold", 8'h60, 8'h70, 2, 1'b1);

    // Reset in the third WRITE cycle of a 5-byte copy.
    for (int a = 8'h80; a < 8'h85; a++) poke(8'(a), 8'(8'hC0 + a));
    @(negedge clk);
    Start = 1'b1; SrcAddr = 8'h90; DstAddr = 8'h80; Len = 8'd5;
    @(posedge clk);
    #1;
    Start = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("rstmid_pre_write", WriteMem, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("rstmid_write", WriteMem, 0);
    checkOutput("rstmid_busy", Busy, 0);
    modelCopy(8'h90, 8'h80, 2, dummy);
    done_seen = 1'b0;
    repeat (2) @(negedge clk) done_seen |= Done;
    rst_n = 1'b1;
    repeat (4) @(negedge clk) done_seen |= Done | Busy;
    checkOutput("rstmid_no_done", done_seen, 0);
    checkOutput("rstmid_idle_addr", DataAddress, 0);
    checkMemory("rstmid");

    // Randomized copies against the reference model.
    for (int r = 0; r < 8; r++) begin
      applyStimulus($sformatf("rand%0d", r), 8'($urandom), 8'($urandom),
                    int'($urandom_range(1, 12)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
